// File: rtl/apes_pkg.sv
// rtl/apes_pkg.sv - shared types and constants for the pulse counter bank
package apes_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_CONT   = 1'b1;

    localparam int DEF_NCH   = 50;
    localparam int DEF_CNT_W = 10;

endpackage

// File: rtl/pulse_ch.sv
// rtl/pulse_ch.sv - one channel: synchroniser, edge detect, stim mux, saturating live counter
module pulse_ch
    import apes_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk50,
    input  logic             rst_n,
    input  logic             inpulse,
    input  logic             stim_pulse,
    input  logic             stim_en,
    input  logic             cnt_en,
    input  logic             clr,
    input  logic             term,
    output logic [CNT_W-1:0] fin_cnt,
    output logic             fin_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] live_q, live_d;
    logic             sat_q, sat_d;
    logic             edge_p;

    always_comb begin
        sync1_d = inpulse;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        edge_p  = stim_en ? stim_pulse : (sync2_q & ~prev_q);

        // Count including this cycle's edge; this is also what the shadow takes on the terminal cycle.
        fin_cnt = (edge_p && (live_q != CNT_MAX)) ? live_q + 1'b1 : live_q;
        fin_sat = sat_q | (edge_p && (live_q >= CNT_MAX - 1'b1));

        live_d = live_q;
        sat_d  = sat_q;
        if (clr || term) begin
            live_d = '0;
            sat_d  = 1'b0;
        end else if (cnt_en) begin
            live_d = fin_cnt;
            sat_d  = fin_sat;
        end
    end

    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            live_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            live_q  <= live_d;
            sat_q   <= sat_d;
        end
    end

endmodule

// File: rtl/pulse_counter_bank.sv
// rtl/pulse_counter_bank.sv - multi-channel windowed pulse counter with shadow bank and read port
module pulse_counter_bank
    import apes_pkg::*;
#(
    parameter int NCH      = DEF_NCH,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int WIN_W    = 24,
    parameter int STIM_DIV = 500,
    localparam int AW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk50,
    input  logic             rst_n,
    input  logic [NCH-1:0]   inpulse,
    input  logic             stim_en,
    input  logic             mode,
    input  logic [WIN_W-1:0] win_len,
    input  logic             cnt_start,
    input  logic             cnt_clr,
    output logic             cnt_done,
    output logic             busy,
    output logic             sat_any,
    input  logic [AW-1:0]    rd_addr,
    output logic [CNT_W-1:0] rd_data
);

    localparam int               DIV_W    = $clog2(STIM_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STIM_DIV - 1);

    state_e           state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d, win_load;
    logic [DIV_W-1:0] div_q, div_d;
    logic             stim_q, stim_d;
    logic             done_q, done_d;
    logic             sat_any_q, sat_any_d;
    logic [CNT_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] shadow_q [NCH];
    logic [CNT_W-1:0] shadow_d [NCH];
    logic [CNT_W-1:0] fin_cnt [NCH];
    logic [NCH-1:0]   fin_sat;
    logic             cnt_en, term, start_ok, clr_live;

    always_comb begin
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        stim_d   = (div_q == DIV_LAST);
        win_load = (win_len == '0) ? '0 : win_len - 1'b1;
        cnt_en   = (state_q == COUNT);
        term     = cnt_en && (win_q == '0);
        start_ok = (state_q == IDLE) && cnt_start && !cnt_clr;
        clr_live = cnt_clr || start_ok;

        state_d   = state_q;
        win_d     = win_q;
        done_d    = 1'b0;
        sat_any_d = sat_any_q;
        shadow_d  = shadow_q;

        if (cnt_clr) begin
            state_d   = IDLE;
            sat_any_d = 1'b0;
            for (int i = 0; i < NCH; i++) shadow_d[i] = '0;
        end else if (start_ok) begin
            state_d = COUNT;
            win_d   = win_load;
        end else if (term) begin
            done_d    = 1'b1;
            sat_any_d = |fin_sat;
            for (int i = 0; i < NCH; i++) shadow_d[i] = fin_cnt[i];
            case (mode)
                MODE_SINGLE: state_d = IDLE;
                MODE_CONT:   win_d   = win_load;
            endcase
        end else if (cnt_en) begin
            win_d = win_q - 1'b1;
        end

        // Reads the pre-update shadow when a window closes on the same edge.
        rd_d = (int'(rd_addr) < NCH) ? shadow_q[rd_addr] : '0;
    end

    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            win_q     <= '0;
            div_q     <= '0;
            stim_q    <= 1'b0;
            done_q    <= 1'b0;
            sat_any_q <= 1'b0;
            rd_q      <= '0;
            for (int i = 0; i < NCH; i++) shadow_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            div_q     <= div_d;
            stim_q    <= stim_d;
            done_q    <= done_d;
            sat_any_q <= sat_any_d;
            rd_q      <= rd_d;
            shadow_q  <= shadow_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        pulse_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk50      (clk50),
            .rst_n      (rst_n),
            .inpulse    (inpulse[g]),
            .stim_pulse (stim_q),
            .stim_en    (stim_en),
            .cnt_en     (cnt_en),
            .clr        (clr_live),
            .term       (term),
            .fin_cnt    (fin_cnt[g]),
            .fin_sat    (fin_sat[g])
        );
    end

    assign busy     = (state_q == COUNT);
    assign cnt_done = done_q;
    assign sat_any  = sat_any_q;
    assign rd_data  = rd_q;

endmodule

// File: tb/tb_pulse_counter_bank.sv
// tb/tb_pulse_counter_bank.sv - randomized and directed bench against a behavioural window model
module tb_pulse_counter_bank;

    localparam int NCH      = 6;
    localparam int CNT_W    = 4;
    localparam int WIN_W    = 16;
    localparam int STIM_DIV = 500;
    localparam int AW       = 3;
    localparam int MAXC     = (1 << CNT_W) - 1;

    logic             clk50 = 1'b0;
    logic             rst_n;
    logic [NCH-1:0]   inpulse;
    logic             stim_en;
    logic             mode;
    logic [WIN_W-1:0] win_len;
    logic             cnt_start;
    logic             cnt_clr;
    logic             cnt_done;
    logic             busy;
    logic             sat_any;
    logic [AW-1:0]    rd_addr;
    logic [CNT_W-1:0] rd_data;

    always #10 clk50 = ~clk50;

    pulse_counter_bank #(
        .NCH(NCH), .CNT_W(CNT_W), .WIN_W(WIN_W), .STIM_DIV(STIM_DIV)
    ) dut (
        .clk50     (clk50),
        .rst_n     (rst_n),
        .inpulse   (inpulse),
        .stim_en   (stim_en),
        .mode      (mode),
        .win_len   (win_len),
        .cnt_start (cnt_start),
        .cnt_clr   (cnt_clr),
        .cnt_done  (cnt_done),
        .busy      (busy),
        .sat_any   (sat_any),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    // Behavioural model: unbounded true counts per window, saturated only when published.
    bit             m_busy, m_done, m_sat_any;
    int             m_rem, m_rd, ncyc;
    int             m_live [NCH];
    int             m_shadow [NCH];
    logic [NCH-1:0] h1, h2, h3;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        logic [NCH-1:0] ev;
        bit stim_hit, any;
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_sat_any = 0; m_rem = 0; m_rd = 0; ncyc = 0;
            h1 = '0; h2 = '0; h3 = '0;
            for (int c = 0; c < NCH; c++) begin
                m_live[c] = 0;
                m_shadow[c] = 0;
            end
            return;
        end
        ncyc++;
        stim_hit = (ncyc > 1) && (((ncyc - 1) % STIM_DIV) == 0);
        // An input first seen high at edge j is counted at edge j+2.
        ev = stim_en ? {NCH{stim_hit}} : (h2 & ~h3);
        h3 = h2; h2 = h1; h1 = inpulse;
        m_rd = (int'(rd_addr) < NCH) ? m_shadow[rd_addr] : 0;
        m_done = 0;
        if (cnt_clr) begin
            m_busy = 0;
            m_sat_any = 0;
            for (int c = 0; c < NCH; c++) begin
                m_live[c] = 0;
                m_shadow[c] = 0;
            end
        end else if (!m_busy) begin
            if (cnt_start) begin
                m_busy = 1;
                m_rem = (win_len == 0) ? 1 : int'(win_len);
                for (int c = 0; c < NCH; c++) m_live[c] = 0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) m_live[c] += int'(ev[c]);
            m_rem--;
            if (m_rem == 0) begin
                any = 0;
                for (int c = 0; c < NCH; c++) begin
                    m_shadow[c] = (m_live[c] < MAXC) ? m_live[c] : MAXC;
                    if (m_live[c] >= MAXC) any = 1;
                    m_live[c] = 0;
                end
                m_sat_any = any;
                m_done = 1;
                if (mode) m_rem = (win_len == 0) ? 1 : int'(win_len);
                else m_busy = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk50);
        model_step();
        @(negedge clk50);
        chk("busy", int'(busy), int'(m_busy));
        chk("cnt_done", int'(cnt_done), int'(m_done));
        chk("sat_any", int'(sat_any), int'(m_sat_any));
        chk("rd_data", int'(rd_data), m_rd);
        if (cnt_done) done_seen++;
    endtask

    task automatic do_reset();
        inpulse = '0; stim_en = 0; mode = 0; win_len = '0;
        cnt_start = 0; cnt_clr = 0; rd_addr = '0;
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic start_win(input int len, input bit md);
        win_len = WIN_W'(len);
        mode = md;
        cnt_start = 1;
        tick();
        cnt_start = 0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!cnt_done && n < budget) begin
            tick();
            n++;
        end
        chk("wait_done", int'(cnt_done), 1);
    endtask

    task automatic read_ch(input int addr, input int exp);
        rd_addr = AW'(addr);
        tick();
        chk($sformatf("rd_lit_%0d", addr), int'(rd_data), exp);
    endtask

    task automatic pulse(input int ch, input int n);
        repeat (n) begin
            inpulse[ch] = 1'b1; tick(); tick();
            inpulse[ch] = 1'b0; tick(); tick();
        end
    endtask

    initial begin
        do_reset();
        chk("rst_busy", int'(busy), 0);
        chk("rst_rd", int'(rd_data), 0);

        // Single window, 7 pulses on ch0
        start_win(100, 0);
        done_seen = 0;
        pulse(0, 7);
        wait_done(200);
        read_ch(0, 7);
        read_ch(1, 0);
        repeat (20) tick();
        chk("single_busy", int'(busy), 0);
        chk("single_done_cnt", done_seen, 1);

        // Continuous stimulus windows
        do_reset();
        stim_en = 1;
        start_win(5000, 1);
        done_seen = 0;
        for (int w = 0; w < 3; w++) begin
            wait_done(5100);
            if (w == 1) mode = 0;
            for (int c = 0; c < NCH; c++) read_ch(c, 10);
        end
        repeat (10) tick();
        chk("cont_done_cnt", done_seen, 3);
        chk("cont_busy", int'(busy), 0);
        stim_en = 0;

        // Saturation, clean window, saturation again, then clr with start
        do_reset();
        start_win(200, 0);
        pulse(3, 20);
        wait_done(300);
        read_ch(3, 15);
        chk("sat_set", int'(sat_any), 1);
        start_win(10, 0);
        wait_done(50);
        chk("sat_clean", int'(sat_any), 0);
        read_ch(3, 0);
        start_win(200, 0);
        pulse(3, 20);
        wait_done(300);
        read_ch(3, 15);
        cnt_clr = 1; cnt_start = 1;
        tick();
        cnt_clr = 0; cnt_start = 0;
        tick();
        chk("clr_start_busy", int'(busy), 0);
        chk("clr_start_sat", int'(sat_any), 0);
        read_ch(3, 0);

        // cnt_clr mid-window
        start_win(50, 0);
        pulse(1, 2);
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        done_seen = 0;
        repeat (60) tick();
        chk("clr_mid_done", done_seen, 0);
        chk("clr_mid_busy", int'(busy), 0);

        // Window boundary: ch2 lands on the terminal edge, ch3 one edge later
        do_reset();
        start_win(20, 1);
        repeat (17) tick();
        inpulse[2] = 1; tick();
        inpulse[2] = 0; inpulse[3] = 1; tick();
        inpulse[3] = 0; tick();
        chk("bnd_done", int'(cnt_done), 1);
        mode = 0;
        read_ch(2, 1);
        read_ch(3, 0);
        wait_done(40);
        read_ch(2, 0);
        read_ch(3, 1);

        // Reset mid-window
        start_win(50, 0);
        pulse(4, 3);
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(cnt_done), 0);
        chk("mrst_sat", int'(sat_any), 0);
        chk("mrst_rd", int'(rd_data), 0);
        read_ch(6, 0);
        read_ch(7, 0);
        done_seen = 0;
        repeat (60) tick();
        chk("mrst_no_done", done_seen, 0);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 6000; n++) begin
            rst_n     = ($urandom_range(0, 999) != 0);
            cnt_start = ($urandom_range(0, 7) == 0);
            cnt_clr   = ($urandom_range(0, 299) == 0);
            win_len   = WIN_W'($urandom_range(0, 60));
            rd_addr   = AW'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            if ($urandom_range(0, 99) == 0) stim_en = ~stim_en;
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 2) == 0) inpulse[c] = ~inpulse[c];
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
